// File: rtl/pc_gen_pkg.sv
// Shared pipeline constants: PC defaults, redirect-select codes, pending-register states.
package pc_gen_pkg;

    localparam int unsigned PC_W = 32;
    localparam logic [PC_W-1:0] RESET_PC = 32'h0000_3000;
    localparam logic [PC_W-1:0] EXC_PC   = 32'h0000_4180;

    // Next-PC source select
    localparam int unsigned SEL_W = 3;
    localparam logic [2:0] SEL_SEQ  = 3'd0;
    localparam logic [2:0] SEL_BR   = 3'd1;
    localparam logic [2:0] SEL_J    = 3'd2;
    localparam logic [2:0] SEL_JR   = 3'd3;
    localparam logic [2:0] SEL_PEND = 3'd4;
    localparam logic [2:0] SEL_EPC  = 3'd5;
    localparam logic [2:0] SEL_EXC  = 3'd6;
    localparam logic [2:0] SEL_HOLD = 3'd7;

    // Pending redirect register states
    localparam logic [0:0] PEND_EMPTY = 1'b0;
    localparam logic [0:0] PEND_HELD  = 1'b1;

endpackage

// File: rtl/pc_gen_npc_calc.sv
// Combinational branch and jump target arithmetic for the D-stage instruction.
module npc_calc #(
    parameter int unsigned AW = 32
) (
    input  logic [AW-1:0] pc4_d,
    input  logic [15:0]   br_off,
    input  logic [25:0]   instr_index,
    output logic [AW-1:0] br_target_c,
    output logic [AW-1:0] j_target_c
);

    // Word offset sign-extended to AW bits and scaled to bytes
    assign br_target_c = pc4_d + {{(AW-18){br_off[15]}}, br_off, 2'b00};

    // Jump keeps the region bits above the 28-bit field when there are any
    if (AW > 28) begin : g_region
        assign j_target_c = {pc4_d[AW-1:28], instr_index, 2'b00};
    end else begin : g_no_region
        assign j_target_c = AW'({instr_index, 2'b00});
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter with redirect priority and a one-deep pending redirect.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned    AW       = 32,
    parameter logic [AW-1:0]  RESET_PC = AW'(pc_gen_pkg::RESET_PC),
    parameter logic [AW-1:0]  EXC_PC   = AW'(pc_gen_pkg::EXC_PC)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_d,
    input  logic          f_busy,
    input  logic          br_take,
    input  logic [15:0]   br_off,
    input  logic          j_take,
    input  logic [25:0]   instr_index,
    input  logic          jr_take,
    input  logic [AW-1:0] jr_target,
    input  logic [AW-1:0] pc4_d,
    input  logic          exc_req,
    input  logic          eret,
    input  logic [AW-1:0] epc,
    output logic [AW-1:0] pc_f,
    output logic [AW-1:0] pc4_f,
    output logic          adel_f,
    output logic          redir_pend
);

    logic [AW-1:0]    pc_q;
    logic [AW-1:0]    pend_target_q;
    logic [0:0]       pend_state_q;

    logic [AW-1:0]    br_target_c;
    logic [AW-1:0]    j_target_c;
    logic [AW-1:0]    d_target_c;
    logic             d_redir_c;
    logic [SEL_W-1:0] sel_c;
    logic [AW-1:0]    pc_next_c;
    logic [AW-1:0]    pend_target_next_c;
    logic [0:0]       pend_state_next_c;

    npc_calc #(.AW(AW)) u_npc_calc (
        .pc4_d       (pc4_d),
        .br_off      (br_off),
        .instr_index (instr_index),
        .br_target_c (br_target_c),
        .j_target_c  (j_target_c)
    );

    assign d_redir_c  = jr_take | j_take | br_take;
    assign d_target_c = jr_take ? jr_target : (j_take ? j_target_c : br_target_c);

    // Select next-PC source and next pending-register state
    always_comb begin
        sel_c              = SEL_SEQ;
        pend_state_next_c  = pend_state_q;
        pend_target_next_c = pend_target_q;
        if (exc_req) begin
            sel_c             = SEL_EXC;
            pend_state_next_c = PEND_EMPTY;
        end else if (eret) begin
            sel_c             = SEL_EPC;
            pend_state_next_c = PEND_EMPTY;
        end else if (f_busy) begin
            sel_c = SEL_HOLD;
            if (!stall_d && d_redir_c) begin
                pend_state_next_c  = PEND_HELD;
                pend_target_next_c = d_target_c;
            end
        end else if (stall_d) begin
            // D re-presents its redirect after the stall; a held redirect waits too
            sel_c = SEL_HOLD;
        end else begin
            pend_state_next_c = PEND_EMPTY;
            if (jr_take)                        sel_c = SEL_JR;
            else if (j_take)                    sel_c = SEL_J;
            else if (br_take)                   sel_c = SEL_BR;
            else if (pend_state_q == PEND_HELD) sel_c = SEL_PEND;
            else                                sel_c = SEL_SEQ;
        end
    end

    // Next-PC mux
    always_comb begin
        pc_next_c = pc_q + AW'(4);
        case (sel_c)
            SEL_EXC:  pc_next_c = EXC_PC;
            SEL_EPC:  pc_next_c = epc;
            SEL_JR:   pc_next_c = jr_target;
            SEL_J:    pc_next_c = j_target_c;
            SEL_BR:   pc_next_c = br_target_c;
            SEL_PEND: pc_next_c = pend_target_q;
            SEL_HOLD: pc_next_c = pc_q;
            default:  pc_next_c = pc_q + AW'(4);
        endcase
    end

    // PC and pending-register state
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            pend_state_q  <= PEND_EMPTY;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_next_c;
            pend_state_q  <= pend_state_next_c;
            pend_target_q <= pend_target_next_c;
        end
    end

    assign pc_f       = pc_q;
    assign pc4_f      = pc_q + AW'(4);
    assign adel_f     = |pc_q[1:0];
    assign redir_pend = (pend_state_q == PEND_HELD);

endmodule

// File: tb/tb_pc_gen.sv
// Directed and random checks of pc_gen against a behavioural next-PC model.
module tb_pc_gen;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          reset, stall_d, f_busy, br_take, j_take, jr_take, exc_req, eret;
    logic [15:0]   br_off;
    logic [25:0]   instr_index;
    logic [AW-1:0] jr_target, pc4_d, epc;
    logic [AW-1:0] pc_f, pc4_f;
    logic          adel_f, redir_pend;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pt;
    bit          m_pv;

    pc_gen #(.AW(AW), .RESET_PC(32'h0000_3000), .EXC_PC(32'h0000_4180)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall_d     (stall_d),
        .f_busy      (f_busy),
        .br_take     (br_take),
        .br_off      (br_off),
        .j_take      (j_take),
        .instr_index (instr_index),
        .jr_take     (jr_take),
        .jr_target   (jr_target),
        .pc4_d       (pc4_d),
        .exc_req     (exc_req),
        .eret        (eret),
        .epc         (epc),
        .pc_f        (pc_f),
        .pc4_f       (pc4_f),
        .adel_f      (adel_f),
        .redir_pend  (redir_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        reset = 0; stall_d = 0; f_busy = 0; br_take = 0; j_take = 0; jr_take = 0;
        exc_req = 0; eret = 0; br_off = '0; instr_index = '0; jr_target = '0;
        pc4_d = '0; epc = '0;
    endtask

    // Target the D stage asks for, from the instruction-set rules
    function automatic logic [31:0] d_target();
        if (jr_take) return jr_target;
        if (j_take)  return (pc4_d & 32'hF000_0000) | (32'(instr_index) * 32'd4);
        return pc4_d + 32'(int'($signed(br_off)) * 4);
    endfunction

    // Apply the current inputs to the model as one clock edge
    task automatic model_edge();
        bit dred;
        dred = br_take || j_take || jr_take;
        if (reset) begin
            m_pc = 32'h0000_3000; m_pv = 0; m_pt = '0;
        end else if (exc_req) begin
            m_pc = 32'h0000_4180; m_pv = 0;
        end else if (eret) begin
            m_pc = epc; m_pv = 0;
        end else if (f_busy) begin
            if (!stall_d && dred) begin
                m_pv = 1; m_pt = d_target();
            end
        end else if (!stall_d) begin
            if (dred)      m_pc = d_target();
            else if (m_pv) m_pc = m_pt;
            else           m_pc = m_pc + 32'd4;
            m_pv = 0;
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".pc"},   pc_f, m_pc);
        check({tag, ".pc4"},  pc4_f, m_pc + 32'd4);
        check({tag, ".adel"}, 32'(adel_f), 32'(m_pc[1:0] != 2'b00));
        check({tag, ".pend"}, 32'(redir_pend), 32'(m_pv));
    endtask

    initial begin
        idle();
        reset = 1;
        step("rst");
        check("rst_pc", pc_f, 32'h3000);
        check("rst_pend", 32'(redir_pend), 32'd0);
        reset = 0;
        step("seq1"); check("seq1_abs", pc_f, 32'h3004);
        step("seq2"); check("seq2_abs", pc_f, 32'h3008);
        step("seq3"); check("seq3_abs", pc_f, 32'h300C);

        pc4_d = 32'h3010; br_take = 1; br_off = 16'hFFFC;
        step("br"); check("br_abs", pc_f, 32'h3000);
        idle(); pc4_d = 32'h3010; j_take = 1; instr_index = 26'h0000C40;
        step("j"); check("j_abs", pc_f, 32'h3100);

        // Redirect captured during a fetch-busy window
        idle(); f_busy = 1; br_take = 1; pc4_d = 32'h3030; br_off = 16'h0004;
        step("busy1"); check("busy1_pend", 32'(redir_pend), 32'd1);
        check("busy1_hold", pc_f, 32'h3100);
        br_take = 0;
        step("busy2"); step("busy3"); check("busy3_hold", pc_f, 32'h3100);
        f_busy = 0;
        step("apply"); check("apply_abs", pc_f, 32'h3040);
        check("apply_pend", 32'(redir_pend), 32'd0);

        // Later redirect overwrites the pending target
        idle(); f_busy = 1; br_take = 1; pc4_d = 32'h3030; br_off = 16'h0004;
        step("ow1");
        idle(); f_busy = 1; j_take = 1; pc4_d = 32'h3030; instr_index = 26'h0001000;
        step("ow2");
        idle();
        step("ow3"); check("ow_abs", pc_f, 32'h4000);

        // Stall ignores D redirects
        idle(); stall_d = 1; br_take = 1; pc4_d = 32'h3030; br_off = 16'h0010;
        step("stall"); check("stall_abs", pc_f, 32'h4000);

        idle(); stall_d = 1; exc_req = 1;
        step("exc"); check("exc_abs", pc_f, 32'h4180);
        idle(); eret = 1; epc = 32'h3020;
        step("eret"); check("eret_abs", pc_f, 32'h3020);

        idle(); jr_take = 1; jr_target = 32'h3002;
        step("jr"); check("jr_abs", pc_f, 32'h3002);
        check("jr_adel", 32'(adel_f), 32'd1);

        // Reset discards a held redirect
        idle(); f_busy = 1; br_take = 1; pc4_d = 32'h3030; br_off = 16'h0004;
        step("hold");
        idle(); reset = 1; f_busy = 1; exc_req = 1;
        step("rsthold"); check("rsthold_pc", pc_f, 32'h3000);
        check("rsthold_pend", 32'(redir_pend), 32'd0);

        // Sequential wrap
        idle(); jr_take = 1; jr_target = 32'hFFFF_FFFC;
        step("top");
        idle();
        step("wrap"); check("wrap_abs", pc_f, 32'h0000_0000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            exc_req     = ($urandom_range(0, 31) == 0);
            eret        = ($urandom_range(0, 31) == 0);
            f_busy      = ($urandom_range(0, 2) == 0);
            stall_d     = ($urandom_range(0, 3) == 0);
            br_take     = ($urandom_range(0, 3) == 0);
            j_take      = ($urandom_range(0, 5) == 0);
            jr_take     = ($urandom_range(0, 5) == 0);
            br_off      = 16'($urandom);
            instr_index = 26'($urandom);
            pc4_d       = $urandom & 32'hFFFF_FFFC;
            jr_target   = $urandom;
            if ($urandom_range(0, 7) != 0) jr_target[1:0] = 2'b00;
            epc         = $urandom & 32'hFFFF_FFFC;
            step("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter AW, default 32: program counter width; SHALL be >= 28.
REQ-002 Parameter RESET_PC, default 32'h0000_3000: PC value loaded on reset.
REQ-003 Parameter EXC_PC, default 32'h0000_4180: exception entry address.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 stall_d  in  1  decode stall; holds the PC.
REQ-007 f_busy  in  1  fetch port busy; holds the PC, and any redirect is latched.
REQ-008 br_take  in  1  taken conditional branch in D.
REQ-009 br_off  in  16  branch immediate, word offset.
REQ-010 j_take  in  1  j/jal in D.
REQ-011 instr_index  in  26  jump field.
REQ-012 jr_take  in  1  jr/jalr in D.
REQ-013 jr_target  in  AW  register target.
REQ-014 pc4_d  in  AW  PC+4 of the D-stage instruction.
REQ-015 exc_req  in  1  exception commit.
REQ-016 eret  in  1  return from exception.
REQ-017 epc  in  AW  return address for eret.
REQ-018 pc_f  out  AW  current fetch PC.
REQ-019 pc4_f  out  AW  pc_f+4.
REQ-020 adel_f  out  1  pc_f misaligned (pc_f[1:0] != 0).
REQ-021 redir_pend  out  1  a latched redirect is waiting.

Function
REQ-022 Branch target SHALL be pc4_d + (sign-extended br_off << 2), truncated to AW bits.
REQ-023 Jump target SHALL be {pc4_d[AW-1:28], instr_index, 2'b00}.
REQ-024 Redirect priority, highest first: exc_req (EXC_PC), eret (epc), jr_take (jr_target), j_take, br_take, then sequential (pc_f+4).
REQ-025 exc_req or eret SHALL update the PC on the next edge regardless of stall_d or f_busy.
REQ-026 exc_req or eret SHALL clear any pending redirect on the same edge.
REQ-027 With stall_d=1 and f_busy=0, the PC SHALL hold and D-stage redirects SHALL be ignored, because D re-presents them after the stall.
REQ-028 With f_busy=1, the PC SHALL hold.
REQ-029 A D-stage redirect arriving while f_busy=1 and stall_d=0 SHALL be captured in the pending register, and redir_pend SHALL go to 1 on the next edge.
REQ-030 A later D redirect during the same busy window SHALL overwrite the pending target.
REQ-031 On the first edge with f_busy=0 and no exc_req/eret, the PC SHALL load the pending target (a new D redirect in that cycle wins) and redir_pend SHALL clear.
REQ-032 Latency: every redirect SHALL be visible on pc_f one cycle after the edge at which it is accepted; there is no combinational path from inputs to pc_f.
REQ-033 adel_f and pc4_f SHALL be combinational from pc_f.
REQ-034 A misaligned jr_target SHALL be loaded unchanged; adel_f flags it.
REQ-035 Sequential increment SHALL wrap modulo 2^AW without any flag.
REQ-036 Pending-register states are EMPTY and HELD:
 - EMPTY->HELD on a captured redirect.
 - HELD->EMPTY on apply, exc_req, eret or reset.

Reset
REQ-037 On reset: pc_f=RESET_PC, pc4_f=RESET_PC+4, adel_f=0, redir_pend=0, pending target=0.
REQ-038 Reset SHALL override every other input, including exc_req.
REQ-039 Reset asserted mid-pending SHALL discard the pending redirect.

Structure
REQ-040 RESET_PC, EXC_PC and the redirect-select encoding SHALL live in the shared pipeline package.
REQ-041 Target arithmetic (REQ-022/023) SHALL be one combinational sub-module, npc_calc, instantiated once.
REQ-042 The PC register and pending register SHALL reside in pc_gen.

Verification
REQ-043 Reset, then 3 free cycles -> pc_f = 0x3000, 0x3004, 0x3008, 0x300C.
REQ-044 pc4_d=0x3010, br_take=1, br_off=0xFFFC -> next pc_f=0x3000; same with j_take=1, instr_index=0x0000C40 -> pc_f=0x3100.
REQ-045 f_busy=1 for 3 cycles, br_take (target 0x3040) in cycle 1 -> redir_pend=1, pc_f held; f_busy drops -> pc_f=0x3040 next edge, redir_pend=0.
REQ-046 stall_d=1 with exc_req=1 -> pc_f=0x4180 next edge; eret with epc=0x3020 -> pc_f=0x3020.
REQ-047 jr_take, jr_target=0x3002 -> pc_f=0x3002 and adel_f=1.
REQ-048 Reset during HELD -> pc_f=0x3000 and redir_pend=0 after that edge; pc_f=0xFFFFFFFC sequential -> pc_f=0x00000000.
